// File: rtl/uart_pkg.sv
// Shared UART definitions: the fixed button message and FSM state encodings.
package uart_pkg;

   localparam logic [7:0] MSG [5] = '{8'h48, 8'h69, 8'h21, 8'h0D, 8'h0A};
   localparam int unsigned MSG_LEN = $size(MSG);
   localparam int unsigned IDX_W   = $clog2(MSG_LEN);

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_LOAD,
      SEQ_SEND
   } seq_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // Message byte lookup; indices past the end read as zero.
   function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] i);
      logic [7:0] b;
      b = 8'h00;
      for (int k = 0; k < int'(MSG_LEN); k++) begin
         if (i == IDX_W'(k)) b = MSG[k];
      end
      return b;
   endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter: one byte per start pulse, LSB first, registered tx.
module uart_tx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

   tx_state_t         state, state_next;
   logic [BAUD_W-1:0] baud_cnt;
   logic [3:0]        bit_cnt;
   logic [7:0]        shreg;
   logic              baud_last;
   logic              tx_c;
   logic              done_c;

   assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= TX_IDLE;
      else     state <= state_next;
   end

   // Next-state: each non-idle state holds for whole bit periods.
   always_comb begin
      state_next = state;
      case (state)
         TX_IDLE:  if (start) state_next = TX_START;
         TX_START: if (baud_last) state_next = TX_DATA;
         TX_DATA:  if (baud_last && bit_cnt == 4'd7) state_next = TX_STOP;
         TX_STOP:  if (baud_last) state_next = TX_IDLE;
         default:  state_next = TX_IDLE;
      endcase
   end

   // Line level and end-of-frame strobe decoded from the current state.
   always_comb begin
      tx_c   = 1'b1;
      done_c = 1'b0;
      case (state)
         TX_START: tx_c = 1'b0;
         TX_DATA:  tx_c = shreg[0];
         TX_STOP:  done_c = baud_last;
         default:  tx_c = 1'b1;
      endcase
   end

   // Baud and bit counters plus the data shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
      end else begin
         if (state == TX_IDLE || baud_last) baud_cnt <= '0;
         else                               baud_cnt <= baud_cnt + BAUD_W'(1);

         if (state != TX_DATA) bit_cnt <= '0;
         else if (baud_last)   bit_cnt <= bit_cnt + 4'd1;

         if (state == TX_IDLE && start)          shreg <= data;
         else if (state == TX_DATA && baud_last) shreg <= {1'b0, shreg[7:1]};
      end
   end

   // Registered outputs; done lands on the last line cycle of the stop bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx   <= 1'b1;
         done <= 1'b0;
      end else begin
         tx   <= tx_c;
         done <= done_c;
      end
   end

endmodule

// File: rtl/press_msg_tx.sv
// Sends the fixed message once per button press, queueing up to three presses.
module press_msg_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned BAUD         = 115_200,
   parameter int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       press_pulse,
   output logic       tx,
   output logic       busy,
   output logic [1:0] pending,
   output logic       dropped
);

   seq_state_t       state, state_next;
   logic [IDX_W-1:0] idx;
   logic             core_start_c;
   logic [7:0]       core_data_c;
   logic             core_done;
   logic             last_byte;
   logic             msg_end;
   logic             enq;
   logic             deq;

   assign last_byte = (idx == IDX_W'(MSG_LEN - 1));
   assign msg_end   = (state == SEQ_SEND) && core_done && last_byte;
   // A press while idle with nothing queued starts directly; otherwise it queues.
   assign enq       = press_pulse && (state != SEQ_IDLE || pending != 2'd0);
   assign deq       = (msg_end || state == SEQ_IDLE) && pending != 2'd0;

   uart_tx_core #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .start (core_start_c),
      .data  (core_data_c),
      .tx    (tx),
      .done  (core_done)
   );

   // Sequencer state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= SEQ_IDLE;
      else     state <= state_next;
   end

   // Sequencer next-state: walk the message, then restart from the queue.
   always_comb begin
      state_next = state;
      case (state)
         SEQ_IDLE: if (press_pulse || pending != 2'd0) state_next = SEQ_LOAD;
         SEQ_LOAD: state_next = SEQ_SEND;
         SEQ_SEND: begin
            if (core_done) begin
               if (!last_byte || pending != 2'd0) state_next = SEQ_LOAD;
               else                               state_next = SEQ_IDLE;
            end
         end
         default:  state_next = SEQ_IDLE;
      endcase
   end

   // Sequencer outputs to the core.
   always_comb begin
      core_start_c = (state == SEQ_LOAD);
      core_data_c  = msg_byte(idx);
   end

   // Byte index, pending queue, drop strobe and busy flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx     <= '0;
         pending <= 2'd0;
         dropped <= 1'b0;
         busy    <= 1'b0;
      end else begin
         if (state == SEQ_SEND && core_done) begin
            if (last_byte) idx <= '0;
            else           idx <= idx + IDX_W'(1);
         end

         case ({enq, deq})
            2'b10:   if (pending != 2'd3) pending <= pending + 2'd1;
            2'b01:   pending <= pending - 2'd1;
            default: pending <= pending;
         endcase

         dropped <= enq && !deq && (pending == 2'd3);
         busy    <= (state_next != SEQ_IDLE);
      end
   end

endmodule

// File: tb/tb_press_msg_tx.sv
// Scoreboard bench for press_msg_tx at 10 clocks per bit.
module tb_press_msg_tx;

   localparam int CPB    = 10;
   localparam int FRAME  = 10 * CPB;
   localparam int MSGCYC = 5 * (FRAME + 2);   // press edge to dequeue edge

   typedef struct {
      logic [7:0] b;
      bit         chained;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       press_pulse = 1'b0;
   logic       tx;
   logic       busy;
   logic [1:0] pending;
   logic       dropped;

   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   int   epoch = 0;
   int   drop_cnt = 0;
   exp_t exp_q[$];
   logic [7:0] msg_b [5] = '{8'h48, 8'h69, 8'h21, 8'h0D, 8'h0A};

   press_msg_tx #(
      .CLK_FREQ_HZ (1_000_000),
      .BAUD        (100_000)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .press_pulse (press_pulse),
      .tx          (tx),
      .busy        (busy),
      .pending     (pending),
      .dropped     (dropped)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (dropped) drop_cnt <= drop_cnt + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(output int e);
      @(negedge clk);
      press_pulse = 1'b1;
      @(posedge clk);
      #1;
      press_pulse = 1'b0;
      e = cyc;
   endtask

   task automatic press_at(input int t);
      int e;
      goto(t - 1);
      press(e);
   endtask

   task automatic push_msg(input bit chained_first);
      for (int k = 0; k < 5; k++) begin
         exp_t x;
         x.b       = msg_b[k];
         x.chained = (k != 0) || chained_first;
         exp_q.push_back(x);
      end
   endtask

   // UART monitor: decode frames mid-bit and score them against the queue.
   initial begin : monitor
      int         start_cyc;
      int         last_start;
      int         ep;
      logic [7:0] b;
      logic       stop;
      exp_t       e;
      last_start = 0;
      forever begin
         @(negedge clk);
         if (!rst && tx == 1'b0) begin
            start_cyc = cyc;
            ep        = epoch;
            repeat (CPB + CPB / 2 - 1) @(negedge clk);
            b[0] = tx;
            for (int i = 1; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               b[i] = tx;
            end
            repeat (CPB) @(negedge clk);
            stop = tx;
            repeat (CPB / 2) @(negedge clk);
            if (ep == epoch) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_byte", int'(b), int'(e.b));
                  check("stop_bit", int'(stop), 1);
                  if (e.chained) check("frame_spacing", start_cyc - last_start, FRAME + 2);
               end
            end
            last_start = start_cyc;
         end
      end
   end

   initial begin : main
      int e0;
      int d0;
      int bad;

      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_tx", int'(tx), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_pending", int'(pending), 0);
      check("reset_dropped", int'(dropped), 0);

      // Single press
      press(e0);
      push_msg(1'b0);
      check("busy_after_press", int'(busy), 1);
      goto(e0 + 1);
      check("tx_high_e1", int'(tx), 1);
      goto(e0 + 2);
      check("tx_low_e2", int'(tx), 0);
      goto(e0 + MSGCYC - 1);
      check("busy_before_end", int'(busy), 1);
      goto(e0 + MSGCYC);
      check("busy_falls", int'(busy), 0);
      check("single_pending", int'(pending), 0);
      goto(cyc + 20);

      // Three queued presses during byte 2
      press(e0);
      push_msg(1'b0);
      for (int k = 0; k < 3; k++) begin
         press_at(e0 + 120 + 10 * k);
         push_msg(1'b1);
      end
      goto(e0 + 141);
      check("queued_pending3", int'(pending), 3);
      goto(e0 + MSGCYC - 1);
      check("pending3_before_deq", int'(pending), 3);
      goto(e0 + MSGCYC);
      check("pending_to_2", int'(pending), 2);
      goto(e0 + 2 * MSGCYC);
      check("pending_to_1", int'(pending), 1);
      goto(e0 + 3 * MSGCYC);
      check("pending_to_0", int'(pending), 0);
      goto(e0 + 4 * MSGCYC - 1);
      check("queued_busy_hold", int'(busy), 1);
      goto(e0 + 4 * MSGCYC);
      check("queued_busy_falls", int'(busy), 0);
      goto(cyc + 20);

      // Overflow: fourth queued press is discarded
      d0 = drop_cnt;
      press(e0);
      push_msg(1'b0);
      for (int k = 0; k < 3; k++) begin
         press_at(e0 + 120 + 10 * k);
         push_msg(1'b1);
      end
      check("no_drop_on_3rd", int'(dropped), 0);
      press_at(e0 + 150);
      check("drop_pulse", int'(dropped), 1);
      check("pending_saturated", int'(pending), 3);
      goto(e0 + 151);
      check("drop_one_cycle", int'(dropped), 0);
      goto(e0 + 4 * MSGCYC);
      check("overflow_busy_falls", int'(busy), 0);
      check("drop_count", drop_cnt - d0, 1);
      goto(cyc + 20);

      // Press coincident with the final done while the queue is full
      d0 = drop_cnt;
      press(e0);
      push_msg(1'b0);
      for (int k = 0; k < 3; k++) begin
         press_at(e0 + 120 + 10 * k);
         push_msg(1'b1);
      end
      press_at(e0 + MSGCYC);
      push_msg(1'b1);
      check("simul_pending", int'(pending), 3);
      check("simul_no_drop", int'(dropped), 0);
      goto(e0 + MSGCYC + 1);
      check("simul_no_drop_next", int'(dropped), 0);
      goto(e0 + 5 * MSGCYC - 1);
      check("simul_busy_hold", int'(busy), 1);
      goto(e0 + 5 * MSGCYC);
      check("simul_busy_falls", int'(busy), 0);
      check("simul_drop_count", drop_cnt - d0, 0);
      goto(cyc + 20);

      // Reset asserted mid-DATA of byte 3
      press(e0);
      push_msg(1'b0);
      goto(e0 + 250);
      check("byte3_bit_low", int'(tx), 0);
      #3;
      rst = 1'b1;
      epoch++;
      exp_q.delete();
      #1;
      check("async_rst_tx", int'(tx), 1);
      check("async_rst_busy", int'(busy), 0);
      check("async_rst_pending", int'(pending), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      bad = 0;
      for (int k = 0; k < 200; k++) begin
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
      check("post_rst_idle", bad, 0);
      press(e0);
      push_msg(1'b0);
      goto(e0 + 2);
      check("post_rst_tx_low", int'(tx), 0);
      goto(e0 + MSGCYC);
      check("post_rst_busy_falls", int'(busy), 0);
      goto(cyc + 20);

      // Idle line
      bad = 0;
      for (int k = 0; k < 10_000; k++) begin
         if (tx !== 1'b1 || busy !== 1'b0) bad++;
         @(posedge clk);
         #1;
      end
      check("idle_line", bad, 0);
      check("scoreboard_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
